// File: rtl/cordic_arbiter_pkg.sv
// Shared definitions for the CORDIC request arbiter: FSM state encoding and
// default angle/result widths.
package cordic_pkg;

    localparam int CORDIC_ANGLE_W = 8;
    localparam int CORDIC_DATA_W  = 8;

    // One transaction at a time: grab a requester, kick the engine,
    // wait for its result, hand the result to the consumer.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/cordic_arbiter_if.sv
// Requester / engine / response bundle for cordic_arbiter.
// slave  : the arbiter side (accepts requests, drives the engine and response)
// master : the environment side (requesters, engine model, response consumer)
interface cordic_arbiter_if
    import cordic_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ANGLE_W = CORDIC_ANGLE_W,
    parameter int DATA_W  = CORDIC_DATA_W
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*ANGLE_W-1:0] req_angle;
    logic [NUM_REQ-1:0]         req_ready;

    logic                       eng_start;
    logic [ANGLE_W-1:0]         eng_angle;
    logic                       eng_done;
    logic [DATA_W-1:0]          eng_sine;
    logic [DATA_W-1:0]          eng_cosine;

    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [ID_W-1:0]            rsp_id;
    logic [DATA_W-1:0]          rsp_sine;
    logic [DATA_W-1:0]          rsp_cosine;
    logic                       rsp_err;

    logic                       busy;

    modport slave (
        input  req_valid, req_angle, eng_done, eng_sine, eng_cosine, rsp_ready,
        output req_ready, eng_start, eng_angle, rsp_valid, rsp_id,
               rsp_sine, rsp_cosine, rsp_err, busy
    );

    modport master (
        output req_valid, req_angle, eng_done, eng_sine, eng_cosine, rsp_ready,
        input  req_ready, eng_start, eng_angle, rsp_valid, rsp_id,
               rsp_sine, rsp_cosine, rsp_err, busy
    );

endinterface

// File: rtl/cordic_arbiter_rr.sv
// Round-robin picker: the first requester found after ptr (wrapping) wins.
// Purely combinational; grant is all-zero when nothing is requesting.
module rr_arbiter
    import cordic_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    logic found;
    int   cand;

    // Scan ptr+1 .. ptr+NUM_REQ; the nearest requester takes priority.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[ID_W'(cand)]) begin
                found     = 1'b1;
                grant_idx = ID_W'(cand);
            end
        end
        if (found) grant[grant_idx] = 1'b1;
    end

endmodule

// File: rtl/cordic_arbiter.sv
// Shares one sine/cosine engine between NUM_REQ requesters, one transaction
// in flight at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// Optional watchdog: define CORDIC_ARB_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT cycles, answering with rsp_err=1 and zero results.
module cordic_arbiter
    import cordic_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ANGLE_W = CORDIC_ANGLE_W,
    parameter int DATA_W  = CORDIC_DATA_W,
    parameter int TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             rst,
    cordic_arbiter_if.slave  bus
);

    localparam int ID_W = $clog2(NUM_REQ);

    localparam logic [1:0] ST_IDLE  = S_IDLE;
    localparam logic [1:0] ST_ISSUE = S_ISSUE;
    localparam logic [1:0] ST_WAIT  = S_WAIT;
    localparam logic [1:0] ST_RESP  = S_RESP;

    logic [1:0]                       state;
    logic [ID_W-1:0]                  ptr;
    logic [ID_W-1:0]                  gnt_id;
    logic [ANGLE_W-1:0]               angle_q;
    logic [DATA_W-1:0]                sine_q;
    logic [DATA_W-1:0]                cosine_q;

    logic [NUM_REQ-1:0]               arb_gnt;
    logic [ID_W-1:0]                  arb_idx;
    logic [NUM_REQ-1:0][ANGLE_W-1:0]  angles;

    // Same bits as the flat bus, just indexable per requester.
    assign angles = bus.req_angle;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req       (bus.req_valid),
        .ptr       (ptr),
        .grant     (arb_gnt),
        .grant_idx (arb_idx)
    );

`ifdef CORDIC_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;
    logic             wd_fire;

    assign wd_fire = (wait_cnt == CNT_W'(TIMEOUT - 1));

    // Counts WAIT cycles; cleared in ISSUE so every WAIT starts at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    wait_cnt <= '0;
        else if (state == ST_ISSUE) wait_cnt <= '0;
        else if (state == ST_WAIT)  wait_cnt <= wait_cnt + 1'b1;
    end

    // Error flag follows how the last WAIT ended: engine result or watchdog.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else if (state == ST_WAIT) begin
            if (bus.eng_done)  err_q <= 1'b0;
            else if (wd_fire)  err_q <= 1'b1;
        end
    end

    assign bus.rsp_err = err_q;
`else
    logic wd_fire;
    logic unused_timeout;

    // Without the watchdog WAIT only ends on eng_done; TIMEOUT stays in the
    // parameter list so both builds share one instantiation.
    assign wd_fire        = 1'b0;
    assign unused_timeout = (TIMEOUT > 0);
    assign bus.rsp_err    = 1'b0;
`endif

    // Transaction FSM plus the registers it latches along the way.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            ptr      <= ID_W'(NUM_REQ - 1);
            gnt_id   <= '0;
            angle_q  <= '0;
            sine_q   <= '0;
            cosine_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|bus.req_valid) begin
                        gnt_id  <= arb_idx;
                        angle_q <= angles[arb_idx];
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // eng_done here belongs to nobody and is dropped.
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.eng_done) begin
                        sine_q   <= bus.eng_sine;
                        cosine_q <= bus.eng_cosine;
                        state    <= ST_RESP;
                    end else if (wd_fire) begin
                        sine_q   <= '0;
                        cosine_q <= '0;
                        state    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        ptr   <= gnt_id;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Accept is combinational in IDLE so the grant and the latch share a cycle.
    assign bus.req_ready  = (state == ST_IDLE) ? arb_gnt : '0;
    assign bus.eng_start  = (state == ST_ISSUE);
    assign bus.eng_angle  = angle_q;
    assign bus.rsp_valid  = (state == ST_RESP);
    assign bus.rsp_id     = gnt_id;
    assign bus.rsp_sine   = sine_q;
    assign bus.rsp_cosine = cosine_q;
    assign bus.busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed + randomized bench for cordic_arbiter. The reference model keeps
// only "who was served last" and picks the next requester by scanning forward.
module tb_cordic_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TO = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cordic_arbiter_if #(.NUM_REQ(N), .ANGLE_W(AW), .DATA_W(DW)) bus ();

    cordic_arbiter #(.NUM_REQ(N), .ANGLE_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int last_g;
    logic [N-1:0][AW-1:0] ang;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_pick(input logic [N-1:0] m);
        for (int k = 1; k <= N; k++) begin
            if (m[(last_g + k) % N]) return (last_g + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [33:0] out_vec();
        return {bus.req_ready, bus.eng_start, bus.eng_angle, bus.rsp_valid, bus.rsp_id,
                bus.rsp_sine, bus.rsp_cosine, bus.rsp_err, bus.busy};
    endfunction

    // Full transaction starting in IDLE at edge+1.
    task automatic txn(input logic [N-1:0] mask, input logic [N-1:0][AW-1:0] a,
                       input int dly, input int stall, input bit early,
                       input logic [DW-1:0] s, input logic [DW-1:0] c);
        int g;
        logic [N-1:0] onehot;
        logic [19:0] exp_rsp;
        bit quiet;
        bit hold_ok;
        g = model_pick(mask);
        onehot = '0;
        onehot[g] = 1'b1;
        exp_rsp = {1'b1, 2'(g), s, c, 1'b0};
        bus.req_angle = a;
        bus.req_valid = mask;
        #1;
        chk("grant", bus.req_ready, onehot);
        tick();
        if (early) begin
            bus.eng_done = 1'b1;
            bus.eng_sine = 8'hEE;
            bus.eng_cosine = 8'hDD;
        end
        #1;
        chk("start", {bus.eng_start, bus.busy, bus.req_ready}, {1'b1, 1'b1, 4'b0000});
        chk("eng_angle", bus.eng_angle, a[g]);
        tick();
        bus.eng_done = 1'b0;
        quiet = 1'b1;
        repeat (dly) begin
            #1;
            if (bus.eng_start || bus.req_ready != '0 || bus.rsp_valid || bus.eng_angle !== a[g])
                quiet = 1'b0;
            tick();
        end
        chk("wait_quiet", quiet, 1'b1);
        bus.eng_done = 1'b1;
        bus.eng_sine = s;
        bus.eng_cosine = c;
        tick();
        bus.eng_done = 1'b0;
        bus.eng_sine = 8'($urandom);
        bus.eng_cosine = 8'($urandom);
        hold_ok = 1'b1;
        repeat (stall) begin
            #1;
            if ({bus.rsp_valid, bus.rsp_id, bus.rsp_sine, bus.rsp_cosine, bus.rsp_err} !== exp_rsp
                || bus.eng_start || bus.req_ready != '0)
                hold_ok = 1'b0;
            tick();
        end
        chk("rsp_hold", hold_ok, 1'b1);
        bus.rsp_ready = 1'b1;
        #1;
        chk("rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_sine, bus.rsp_cosine, bus.rsp_err}, exp_rsp);
        tick();
        bus.rsp_ready = 1'b0;
        chk("back_idle", {bus.rsp_valid, bus.busy}, 2'b00);
        last_g = g;
    endtask

    initial begin
        logic [N-1:0][AW-1:0] a;
        bit no_rsp;
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_angle = '0;
        bus.eng_done = 1'b0;
        bus.eng_sine = '0;
        bus.eng_cosine = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", out_vec(), 64'd0);
        rst = 1'b0;
        tick();
        chk("idle_outs", out_vec(), 64'd0);
        last_g = N - 1;

        // Single requester, engine answers 10 cycles after start.
        a = '0;
        a[0] = 8'h20;
        txn(4'b0001, a, 9, 0, 1'b0, 8'h1F, 8'h37);

        // All requesting: 1,2,3,0,1 since requester 0 was served last.
        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < N; i++) a[i] = 8'($urandom);
            txn(4'b1111, a, t, 0, 1'b0, 8'($urandom), 8'($urandom));
        end
        chk("wrap_last", 32'(last_g), 32'd1);

        // Consumer stalls 5 cycles.
        for (int i = 0; i < N; i++) a[i] = 8'($urandom);
        txn(4'b1010, a, 2, 5, 1'b0, 8'h5A, 8'hA5);

        // Stray eng_done during ISSUE must be dropped.
        for (int i = 0; i < N; i++) a[i] = 8'($urandom);
        txn(4'b0110, a, 3, 1, 1'b1, 8'h11, 8'h22);
        for (int i = 0; i < N; i++) a[i] = 8'($urandom);
        txn(4'b0001, a, 0, 0, 1'b1, 8'h33, 8'h44);

        // Reset while waiting on the engine.
        for (int i = 0; i < N; i++) a[i] = 8'($urandom);
        bus.req_angle = a;
        bus.req_valid = 4'b0100;
        tick();
        bus.req_valid = '0;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        chk("mid_reset", out_vec(), 64'd0);
        tick();
        rst = 1'b0;
        bus.eng_done = 1'b1;
        bus.eng_sine = 8'h77;
        tick();
        bus.eng_done = 1'b0;
        no_rsp = 1'b1;
        repeat (5) begin
            #1;
            if (bus.rsp_valid || bus.busy) no_rsp = 1'b0;
            tick();
        end
        chk("no_rsp_after_reset", no_rsp, 1'b1);
        last_g = N - 1;
        for (int i = 0; i < N; i++) a[i] = 8'($urandom);
        txn(4'b1111, a, 1, 0, 1'b0, 8'h01, 8'h02);

        // Random traffic.
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < N; i++) a[i] = 8'($urandom);
            txn(4'($urandom_range(1, 15)), a, int'($urandom_range(0, 6)),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                8'($urandom), 8'($urandom));
        end
        bus.req_valid = '0;

`ifdef CORDIC_ARB_TIMEOUT_EN
        begin
            int n;
            bus.req_valid = 4'b1000;
            tick();
            bus.req_valid = '0;
            tick();
            n = 0;
            while (n < 100) begin
                #1;
                if (bus.rsp_valid) break;
                tick();
                n++;
            end
            chk("timeout_cycles", 32'(n), 32'(TO));
            chk("timeout_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_sine, bus.rsp_cosine, bus.rsp_err},
                {1'b1, 2'd3, 8'h00, 8'h00, 1'b1});
            bus.rsp_ready = 1'b1;
            tick();
            bus.rsp_ready = 1'b0;
            last_g = 3;
            for (int i = 0; i < N; i++) a[i] = 8'($urandom);
            txn(4'b1001, a, 2, 0, 1'b0, 8'h3C, 8'hC3);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cordic_arbiter.md
CORDIC_ARBITER -- requirements
Module: cordic_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one sine/cosine engine (2..8).
REQ-002 Parameter ANGLE_W, default 8, angle width per requester.
REQ-003 Parameter DATA_W, default 8, sine/cosine result width.
REQ-004 Parameter TIMEOUT, default 32, engine watchdog limit in cycles (used only with CORDIC_ARB_TIMEOUT_EN).
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 req_valid  input  NUM_REQ  per-requester request strobe, held until accepted.
REQ-008 req_angle  input  NUM_REQ*ANGLE_W  packed angles, requester i at bits [i*ANGLE_W +: ANGLE_W].
REQ-009 req_ready  output  NUM_REQ  one-hot accept pulse, one cycle.
REQ-010 eng_start  output  1  one-cycle start pulse to the engine.
REQ-011 eng_angle  output  ANGLE_W  angle to the engine, stable from eng_start until eng_done.
REQ-012 eng_done  input  1  engine result-ready pulse.
REQ-013 eng_sine, eng_cosine  input  DATA_W each  engine results, valid with eng_done.
REQ-014 rsp_valid  output  1  response available.
REQ-015 rsp_ready  input  1  consumer accepts the response.
REQ-016 rsp_id  output  $clog2(NUM_REQ)  index of the served requester.
REQ-017 rsp_sine, rsp_cosine  output  DATA_W each  latched results.
REQ-018 rsp_err  output  1  watchdog-abort flag.
REQ-019 busy  output  1  high in any state other than IDLE.

Function
REQ-020 FSM states are IDLE, ISSUE, WAIT, RESP; exactly one transaction is in flight at a time.
REQ-021 In IDLE with any req_valid set, the block shall grant round-robin from ptr+1 (mod NUM_REQ), pulse req_ready[g], latch the angle and g, and enter ISSUE.
REQ-022 ISSUE shall assert eng_start for exactly one cycle, then enter WAIT.
REQ-023 In WAIT, eng_done shall latch eng_sine/eng_cosine into rsp_sine/rsp_cosine, clear rsp_err, and enter RESP.
REQ-024 In RESP, rsp_valid shall be high; rsp_id/rsp_sine/rsp_cosine/rsp_err shall be held stable while rsp_ready is low.
REQ-025 On rsp_valid && rsp_ready, the block shall set ptr to the granted index and enter IDLE; the next grant is possible on the following cycle.
REQ-026 Minimum latency is: accept at cycle t, eng_start at t+1, rsp_valid on the cycle after eng_done.
REQ-027 eng_done outside WAIT shall be ignored, including when it coincides with eng_start.
REQ-028 ptr shall wrap from NUM_REQ-1 to 0; a lone requester shall be re-granted each transaction.
REQ-029 No req_ready shall pulse outside IDLE; requests arriving while busy shall wait.
REQ-030 Angles shall pass to eng_angle unmodified; results shall not be rescaled.

Reset
REQ-031 On rst: state=IDLE, ptr=NUM_REQ-1 (so requester 0 wins first), req_ready=0, eng_start=0, eng_angle=0, rsp_valid=0, rsp_id=0, rsp_sine=0, rsp_cosine=0, rsp_err=0, busy=0.
REQ-032 Reset mid-transaction shall abort it with no response emitted; any later eng_done is ignored per REQ-027.

Configuration
REQ-033 Macro CORDIC_ARB_TIMEOUT_EN defined: a WAIT cycle counter shall start from 0 on WAIT entry; on reaching TIMEOUT without eng_done, the block shall enter RESP with rsp_err=1 and rsp_sine=rsp_cosine=0.
REQ-034 Macro undefined: no counter is built, WAIT lasts until eng_done, and rsp_err shall be constant 0.

Structure
REQ-035 Shared package cordic_pkg shall hold the FSM state enum and the default ANGLE_W/DATA_W constants.
REQ-036 Round-robin selection shall be the sub-module rr_arbiter (inputs: request vector, ptr; outputs: one-hot grant, grant index).

Verification
REQ-037 Reset then req_valid=4'b0001, angle 8'h20, engine done after 10 cycles with sine 8'h1F / cosine 8'h37 -> req_ready[0] pulse, eng_start one cycle later, rsp_valid with id 0 and sine 8'h1F / cosine 8'h37.
REQ-038 req_valid=4'b1111 held for 4 transactions -> grant order 0,1,2,3, then 0 again (wrap).
REQ-039 rsp_ready low for 5 cycles in RESP -> response held stable, no req_ready pulses, no eng_start.
REQ-040 eng_done asserted during ISSUE -> ignored; FSM stays in WAIT until the next eng_done.
REQ-041 rst asserted in WAIT -> all outputs at reset values immediately; a subsequent eng_done produces no rsp_valid.
REQ-042 With CORDIC_ARB_TIMEOUT_EN and TIMEOUT=32, no eng_done -> rsp_valid exactly 32 WAIT cycles after WAIT entry, with rsp_err=1 and zero results.
